// File: rtl/uart_rx_loader.sv
// UART receiver that loads good bytes into a 64x8 RAM with a ROM-style registered read port.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check; the default build is 8N1.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | line idle, waiting for a low level on the synchronized rx
// S_START     | half a bit into the start bit; a high level here is a glitch
// S_DATA      | sampling 8 data bits at mid-bit, LSB first
// S_PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// S_STOP      | sampling the stop bit; the byte is committed or flagged here
// S_WAIT_HIGH | framing error or break seen, waiting for the line to go high

module uart_rx_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clr,
    input  logic [5:0] rd_addr,
    output logic [7:0] q,
    output logic [5:0] wr_addr,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY  = 3'd5
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic            rx_meta, rxs;
    logic            tick;
    logic            stop_ok;
    logic            frame_hit;
    logic            par_bad;
    logic            commit;
    logic [7:0]      mem [0:63];

`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            par_hit;
    assign par_bad = perr_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        stop_ok   = 1'b0;
        frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
        par_hit   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                        cnt_d   = BIT_LOAD;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    sh_d  = {rxs, sh_q[7:1]};
                    cnt_d = BIT_LOAD;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    // odd number of ones across data + parity bit means mismatch
                    perr_d  = ^{sh_q, rxs};
                    cnt_d   = BIT_LOAD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d   = rxs ? S_IDLE : S_WAIT_HIGH;
                    frame_hit = ~rxs;
                    stop_ok   = rxs & ~par_bad;
`ifdef UART_RX_PARITY_EN
                    par_hit   = perr_q;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // clr takes priority over a commit landing in the same cycle
    assign commit = stop_ok & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
            q          <= '0;
        end else begin
            if (clr) begin
                wr_addr <= '0;
            end else if (stop_ok) begin
                wr_addr <= wr_addr + 6'd1;
            end
            byte_valid <= commit;
            if (commit) begin
                byte_data <= sh_q;
            end
            frame_err <= frame_hit;
            q         <= mem[rd_addr];
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_hit;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_addr] <= sh_q;
        end
    end

endmodule

// File: doc/uart_rx_loader.md
# uart_rx_loader

Serial-in counterpart of the character ROM/TX path: receives 8N1 UART frames on `rx`, writes each good byte into a 64×8 RAM at an auto-incrementing address, and exposes a ROM-compatible read port (6-bit address, registered 8-bit data). The transmit side can then stream user-loaded text instead of fixed ROM contents.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit. Must be ≥ 4; 434 gives 115200 baud at 50 MHz.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: UART line, idle high, asynchronous to `clk`.
- `clr` input 1: synchronous; forces write pointer to 0.
- `rd_addr` input 6: read address.
- `q` output 8: registered read data.
- `wr_addr` output 6: address the next good byte will be written to.
- `byte_valid` output 1: 1-cycle pulse when a byte is written.
- `byte_data` output 8: last good byte; held until the next write.
- `frame_err` output 1: 1-cycle pulse when the stop bit samples low.
- `parity_err` output 1: 1-cycle pulse on a parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- `rx` passes through a 2-flop synchronizer. The FSM sees only the synchronized value (`rxs`).
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
  - IDLE → START: on `rxs` = 0. Bit counter loads `CLKS_PER_BIT/2 - 1` (integer division).
  - START: at counter expiry, if `rxs` = 1 it is a glitch; return to IDLE with no flags. Otherwise go to DATA with bit index 0 and counter `CLKS_PER_BIT-1`.
  - DATA: sample at each expiry, LSB first, into a shift register. After bit 7, go to PARITY if the macro is defined, else STOP.
  - STOP: sample at expiry.
    - `rxs` = 1 and no parity error: commit the byte.
    - `rxs` = 0: pulse `frame_err`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then IDLE. A break never produces repeated frames.
- Commit behaviour:
  - `mem[wr_addr] <= byte`, `byte_data <= byte`, `byte_valid` pulses.
  - `wr_addr` increments modulo 64 (63 → 0, old contents overwritten). There is no full flag.
  - FSM returns to IDLE on the same edge, so back-to-back frames with a one-bit stop are accepted.
- `clr` and a commit in the same cycle: `clr` wins. `wr_addr` goes to 0, no write, no `byte_valid`.
- `clr` does not affect the FSM or RAM contents.
- Read port: `q <= mem[rd_addr]` every posedge.
  - Read and write to the same address in the same cycle return the old data.
- Reset (`rst_n` low, asynchronous): the following take effect immediately:
  - FSM → IDLE.
  - Counters → 0.
  - Synchronizer flops → 1.
  - `wr_addr` = 0, `q` = 0x00, `byte_data` = 0x00.
  - `byte_valid`, `frame_err`, `parity_err` = 0.
  - RAM contents are not reset.
  - A frame in flight during reset is lost. After release, a low `rx` is treated as a new start edge.

## Timing
- Synchronizer latency: 2 cycles from `rx` to `rxs`.
- Sample points, in cycles after IDLE sees `rxs` = 0 (call this cycle E):
  - Start bit: E + `CLKS_PER_BIT/2`.
  - Data bit n: E + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`.
  - Stop bit: E + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, or +10·`CLKS_PER_BIT` with parity.
- `byte_valid`, `frame_err`, `parity_err`, `byte_data` and `wr_addr` update on the edge that takes the stop sample. The pulse is high for exactly that following cycle.
- Read latency: 1 cycle. Data written at edge k is readable via `q` at edge k+1.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1, with the PARITY state between DATA and STOP.
  - Even parity is checked over the data bits plus the parity bit.
  - On mismatch, the flag is latched; at the STOP sample `parity_err` pulses and the byte is not written.
  - If the stop bit is also low, both `parity_err` and `frame_err` pulse, then WAIT_HIGH.
- Not defined:
  - Frame is 8N1. The PARITY state and checker are not compiled; `parity_err` is tied to 0.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8.
- Reset then idle: `q` = 0x00, `wr_addr` = 0, no pulses for 1000 cycles with `rx` = 1.
- Send 0x5C, then 0x0D back-to-back → two `byte_valid` pulses, `wr_addr` = 2. Reading addresses 0 and 1 gives `q` = 0x5C, 0x0D one cycle later.
- 3-cycle low glitch on `rx` → no `byte_valid`, no `frame_err`, `wr_addr` unchanged.
- Frame 0x41 with stop bit low, `rx` held low 40 cycles, then 0x42 → one `frame_err` pulse; only 0x42 is stored at `wr_addr` 0.
- Send 65 bytes with values 0x00–0x40 → `wr_addr` = 1; `mem[0]` = 0x40, `mem[1]` = 0x01. Then assert `clr` in the cycle 0x55 commits → `wr_addr` = 0, no `byte_valid`, `mem[0]` still 0x40.
- With the macro, send 0x7C with parity bit 0 (wrong) → `parity_err` pulse, no write. Send it with parity bit 1 → written. Assert `rst_n` low mid-frame → all outputs go to reset values within the same cycle.
